// File: rtl/fp_mant_divider.sv
// Iterative radix-2 restoring divider for FPU mantissa quotients: one quotient bit per cycle,
// Q = floor(Mx * 2^(WIDTH+1) / My) plus a sticky bit. Define DIV_EARLY_TERM_EN to stop on a zero remainder.
module fp_mant_divider #(
  parameter int WIDTH = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] Mx_conc,
  input  logic [WIDTH-1:0] My_conc,
  output logic [WIDTH+1:0] Q,
  output logic             sticky,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int ITER = WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   dvs_ext;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH+1:0] q_next;
  logic [WIDTH+1:0] q_final;
  logic             last_iter;
  logic             finish_now;

  // One restoring step: subtract only when the divisor fits.
  always_comb begin
    dvs_ext   = {1'b0, dvs};
    qbit      = (rem >= dvs_ext);
    rem_next  = qbit ? (rem - dvs_ext) : rem;
    q_next    = {Q[WIDTH:0], qbit};
    last_iter = (cnt == CW'(ITER - 1));
`ifdef DIV_EARLY_TERM_EN
    // A zero remainder means every remaining quotient bit is 0, so align Q as if they had been shifted in.
    finish_now = last_iter || (rem_next == '0);
    q_final    = q_next << (CW'(ITER - 1) - cnt);
`else
    finish_now = last_iter;
    q_final    = q_next;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      Q           <= '0;
      sticky      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking default here makes done a single-cycle pulse; any branch below may override it.
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rem    <= {1'b0, Mx_conc};
            dvs    <= My_conc;
            cnt    <= '0;
            sticky <= 1'b0;
            if (My_conc == '0) begin
              state       <= S_DONE;
              Q           <= '1;
              busy        <= 1'b0;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              state       <= S_CALC;
              Q           <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (finish_now) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            Q      <= q_final;
            rem    <= rem_next;
            sticky <= (rem_next != '0);
          end else begin
            Q   <= q_next;
            // rem_next < divisor, so its MSB is zero and the shift loses nothing.
            rem <= {rem_next[WIDTH-1:0], 1'b0};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
